// File: rtl/pulse_slot_sched.sv
`default_nettype none
// ============================================================================
// pulse_slot_sched : four saturating pulse counters, read out round-robin
//                    (or from a fixed slot) over an SPI transaction FSM.
// Revision         : 1.0
// ============================================================================
module pulse_slot_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  i_pulse,
   input  logic        i_spi_sot,
   input  logic        i_spi_eot,
   input  logic [15:0] i_spi_rx,
   output logic [15:0] o_spi_tx,
   output logic [1:0]  o_led,
   output logic [1:0]  o_slot,
   output logic        o_busy,
   output logic [7:0]  o_err_cnt
);

   localparam logic [12:0] c_ACC_MAX = 13'h1FFF;
   localparam logic [7:0]  c_ERR_MAX = 8'hFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      XFER   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t      r_state;
   logic [12:0] r_acc [4];
   logic [3:0]  r_ovf;
   logic [1:0]  r_slot;
   logic        r_mode;
   logic [1:0]  r_led;
   logic [7:0]  r_err_cnt;
   logic [15:0] r_cmd;
   logic        w_clr;

   // Read-and-clear of the served slot: a fresh start in IDLE, or an
   // abort-and-restart in XFER (an end strobe on the same cycle wins).
   assign w_clr = i_spi_sot &&
                  ((r_state == IDLE) || ((r_state == XFER) && !i_spi_eot));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            r_acc[i] <= '0;
         end
         r_ovf <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_clr && (r_slot == 2'(i))) begin
               // A pulse landing on the clear cycle becomes the first count.
               r_acc[i] <= {12'd0, i_pulse[i]};
               r_ovf[i] <= 1'b0;
            end else if (i_pulse[i]) begin
               if (r_acc[i] == c_ACC_MAX) begin
                  r_ovf[i] <= 1'b1;
               end else begin
                  r_acc[i] <= r_acc[i] + 13'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_slot    <= 2'd0;
         r_mode    <= 1'b0;
         r_led     <= 2'b11;
         r_err_cnt <= 8'd0;
         r_cmd     <= 16'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_spi_sot) begin
                  r_state <= XFER;
               end
            end
            XFER: begin
               if (i_spi_eot) begin
                  r_cmd   <= i_spi_rx;
                  r_state <= COMMIT;
               end else if (i_spi_sot && (r_err_cnt != c_ERR_MAX)) begin
                  r_err_cnt <= r_err_cnt + 8'd1;
               end
            end
            COMMIT: begin
               r_state <= IDLE;
               if (r_cmd[15]) begin
                  r_led  <= ~r_cmd[1:0];
                  r_mode <= r_cmd[14];
                  if (r_cmd[14]) begin
                     r_slot <= r_cmd[13:12];
                  end else begin
                     r_slot <= r_slot + 2'd1;
                  end
               end else if (!r_mode) begin
                  r_slot <= r_slot + 2'd1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_spi_tx  = {r_slot, r_ovf[r_slot], r_acc[r_slot]};
   assign o_led     = r_led;
   assign o_slot    = r_slot;
   assign o_busy    = (r_state != IDLE);
   assign o_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pulse_slot_sched.sv
`default_nettype none
// ============================================================================
// tb_pulse_slot_sched : directed self-checking bench for pulse_slot_sched.
// Revision            : 1.0
// ============================================================================
module tb_pulse_slot_sched;

   logic        clk;
   logic        rst_n;
   logic [3:0]  r_pulse;
   logic        r_sot;
   logic        r_eot;
   logic [15:0] r_rx;
   logic [15:0] w_tx;
   logic [1:0]  w_led;
   logic [1:0]  w_slot;
   logic        w_busy;
   logic [7:0]  w_err_cnt;

   int n_chk;
   int n_fail;

   pulse_slot_sched u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_pulse   (r_pulse),
      .i_spi_sot (r_sot),
      .i_spi_eot (r_eot),
      .i_spi_rx  (r_rx),
      .o_spi_tx  (w_tx),
      .o_led     (w_led),
      .o_slot    (w_slot),
      .o_busy    (w_busy),
      .o_err_cnt (w_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs are applied at a falling edge, held across one rising edge,
   // and the outputs are sampled at the following falling edge.
   task automatic step(input logic [3:0] p, input logic s, input logic e, input logic [15:0] rx);
      r_pulse = p;
      r_sot   = s;
      r_eot   = e;
      r_rx    = rx;
      @(negedge clk);
      r_pulse = 4'd0;
      r_sot   = 1'b0;
      r_eot   = 1'b0;
      r_rx    = 16'd0;
   endtask

   task automatic xact(input string tag, input logic [15:0] rx, input logic [15:0] exp_tx);
      chk(tag, w_tx, exp_tx);
      step(4'd0, 1'b1, 1'b0, 16'd0);
      step(4'd0, 1'b0, 1'b1, rx);
      step(4'd0, 1'b0, 1'b0, 16'd0);
   endtask

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      r_pulse = 4'd0;
      r_sot   = 1'b0;
      r_eot   = 1'b0;
      r_rx    = 16'd0;
      repeat (2) @(negedge clk);
      chk("rst_tx",   w_tx, 16'h0000);
      chk("rst_led",  {14'd0, w_led}, 16'h0003);
      chk("rst_slot", {14'd0, w_slot}, 16'h0000);
      chk("rst_busy", {15'd0, w_busy}, 16'h0000);
      chk("rst_err",  {8'd0, w_err_cnt}, 16'h0000);
      rst_n = 1'b1;
      @(negedge clk);

      // Five pulses on ch0, then a read of slot 0.
      repeat (5) step(4'b0001, 1'b0, 1'b0, 16'd0);
      chk("ch0_tx", w_tx, 16'h0005);
      step(4'd0, 1'b1, 1'b0, 16'd0);
      chk("ch0_clr",  w_tx, 16'h0000);
      chk("ch0_busy", {15'd0, w_busy}, 16'h0001);
      step(4'd0, 1'b0, 1'b1, 16'h0000);
      chk("commit_busy", {15'd0, w_busy}, 16'h0001);
      step(4'd0, 1'b0, 1'b0, 16'd0);
      chk("ch0_slot", {14'd0, w_slot}, 16'h0001);
      chk("ch0_led",  {14'd0, w_led}, 16'h0003);
      chk("idle_busy", {15'd0, w_busy}, 16'h0000);

      // Pulse coinciding with the clear on slot 1.
      repeat (7) step(4'b0010, 1'b0, 1'b0, 16'd0);
      chk("ch1_tx", w_tx, 16'h4007);
      step(4'b0010, 1'b1, 1'b0, 16'd0);
      chk("ch1_keep", w_tx, 16'h4001);
      step(4'd0, 1'b0, 1'b1, 16'h0000);
      step(4'd0, 1'b0, 1'b0, 16'd0);
      chk("ch1_slot", {14'd0, w_slot}, 16'h0002);

      // Saturation on ch2.
      repeat (9000) step(4'b0100, 1'b0, 1'b0, 16'd0);
      xact("ch2_sat", 16'h0000, 16'hBFFF);
      xact("rd_s3", 16'h0000, 16'hC000);
      xact("rd_s0", 16'h0000, 16'h0000);
      xact("rd_s1", 16'h0000, 16'h4001);
      xact("rd_s2", 16'h0000, 16'h8000);
      chk("wrap_slot", {14'd0, w_slot}, 16'h0003);

      // Abort-and-restart: sot, sot, eot.
      step(4'd0, 1'b1, 1'b0, 16'd0);
      chk("ab_busy1", {15'd0, w_busy}, 16'h0001);
      step(4'd0, 1'b1, 1'b0, 16'd0);
      chk("ab_err",   {8'd0, w_err_cnt}, 16'h0001);
      chk("ab_busy2", {15'd0, w_busy}, 16'h0001);
      step(4'd0, 1'b0, 1'b1, 16'h0000);
      chk("ab_busy3", {15'd0, w_busy}, 16'h0001);
      step(4'd0, 1'b0, 1'b0, 16'd0);
      chk("ab_slot", {14'd0, w_slot}, 16'h0000);
      chk("ab_idle", {15'd0, w_busy}, 16'h0000);

      // sot and eot together in XFER: eot wins, no error counted.
      step(4'd0, 1'b1, 1'b0, 16'd0);
      step(4'd0, 1'b1, 1'b1, 16'h0000);
      chk("se_commit", {15'd0, w_busy}, 16'h0001);
      step(4'd0, 1'b0, 1'b0, 16'd0);
      chk("se_err",  {8'd0, w_err_cnt}, 16'h0001);
      chk("se_slot", {14'd0, w_slot}, 16'h0001);

      // eot in IDLE is ignored.
      step(4'd0, 1'b0, 1'b1, 16'h8003);
      step(4'd0, 1'b0, 1'b0, 16'd0);
      chk("ie_busy", {15'd0, w_busy}, 16'h0000);
      chk("ie_led",  {14'd0, w_led}, 16'h0003);
      chk("ie_slot", {14'd0, w_slot}, 16'h0001);

      // Fixed-mode command with slot 3 and led pattern.
      step(4'd0, 1'b1, 1'b0, 16'd0);
      step(4'd0, 1'b0, 1'b1, 16'hF002);
      chk("fx_led_lat", {14'd0, w_led}, 16'h0003);
      step(4'd0, 1'b0, 1'b0, 16'd0);
      chk("fx_led",  {14'd0, w_led}, 16'h0001);
      chk("fx_slot", {14'd0, w_slot}, 16'h0003);
      for (int k = 0; k < 3; k++) begin
         xact("fx_nop", 16'h0000, 16'hC000);
      end
      chk("fx_hold", {14'd0, w_slot}, 16'h0003);
      chk("fx_led2", {14'd0, w_led}, 16'h0001);
      xact("auto_cmd", 16'h8003, 16'hC000);
      chk("auto_led",  {14'd0, w_led}, 16'h0000);
      chk("auto_slot", {14'd0, w_slot}, 16'h0000);

      // Reset while in XFER.
      step(4'd0, 1'b1, 1'b0, 16'd0);
      chk("mr_busy0", {15'd0, w_busy}, 16'h0001);
      #1 rst_n = 1'b0;
      #1;
      chk("mr_busy", {15'd0, w_busy}, 16'h0000);
      chk("mr_led",  {14'd0, w_led}, 16'h0003);
      chk("mr_err",  {8'd0, w_err_cnt}, 16'h0000);
      chk("mr_tx",   w_tx, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      step(4'd0, 1'b0, 1'b1, 16'hF002);
      step(4'd0, 1'b0, 1'b0, 16'd0);
      chk("mr_eot_busy", {15'd0, w_busy}, 16'h0000);
      chk("mr_eot_slot", {14'd0, w_slot}, 16'h0000);
      chk("mr_eot_led",  {14'd0, w_led}, 16'h0003);
      step(4'd0, 1'b1, 1'b0, 16'd0);
      chk("mr_sot_busy", {15'd0, w_busy}, 16'h0001);
      chk("mr_sot_err",  {8'd0, w_err_cnt}, 16'h0000);
      step(4'd0, 1'b0, 1'b1, 16'h0000);
      step(4'd0, 1'b0, 1'b0, 16'd0);
      chk("mr_slot", {14'd0, w_slot}, 16'h0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
